serial_subtractor: RTL

Sequential bit-serial subtractor that computes diff = A - B one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
It is the inverse-operation companion to the team's ripple adder in the functional-unit set.

---
 rtl/serial_subtractor.sv | 138 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, LSB first, one full-subtractor cell
// plus a borrow flip-flop. One result every WIDTH+1 cycles back-to-back.
//
// Optional feature: define SERIAL_SUB_OVF_EN to add the 'overflow' output
// (signed two's-complement overflow of the completed subtraction).
//
// Handshake: start acts as 'valid' and (state != SHIFT) acts as 'ready';
// an operation is accepted on a rising edge where both are high. A and B are
// only sampled on that edge. done is a one-cycle 'valid' for diff/borrow_out
// with no back-pressure; diff/borrow_out then hold until the next completion.
// The FSM state is kept in the 'state' signal for hierarchical observation.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             overflow,
`endif
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             br;

  logic             accept;
  logic             last;
  logic             a0;
  logic             b0;
  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  // Full-subtractor cell and control decodes.
  always_comb begin
    a0       = a_sr[0];
    b0       = b_sr[0];
    d        = a0 ^ b0 ^ br;
    br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
    res_next = {d, res_sr[WIDTH-1:1]};
    accept   = start && (state != ST_SHIFT);
    last     = (state == ST_SHIFT) && (cnt == LAST_BIT);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; DONE accepts a new start just like IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (cnt == LAST_BIT) state_next = ST_DONE;
      ST_DONE:  state_next = start ? ST_SHIFT : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: done is high exactly while in DONE, so it is a registered pulse.
  always_comb begin
    busy = (state == ST_SHIFT);
    done = (state == ST_DONE);
  end

  // Datapath: capture on accept, one bit per edge in SHIFT, publish on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= A;
      b_sr  <= B;
      br    <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= A[WIDTH-1];
      b_msb <= B[WIDTH-1];
`endif
    end else if (state == ST_SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_next;
      br     <= br_next;
      cnt    <= cnt + CW'(1);
      if (last) begin
        diff       <= res_next;
        borrow_out <= br_next;
`ifdef SERIAL_SUB_OVF_EN
        // d is the MSB of the completed difference on this edge.
        overflow   <= (a_msb != b_msb) && (d != a_msb);
`endif
      end
    end
  end

endmodule
